// File: rtl/auth_request_arbiter_pkg.sv
// Shared constants for the PD/DEBUG authentication request arbiter:
// FSM encodings, source identifiers and the tie-break helper.
`timescale 1ns/1ps
package auth_request_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic SRC_PD    = 1'b0;
    localparam logic SRC_DEBUG = 1'b1;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;
    localparam int TO_W_DEFAULT           = 11;

    // Returns the source to grant; only meaningful when at least one is eligible.
    function automatic logic pick_source(input logic pd_elig,
                                         input logic dbg_elig,
                                         input logic last_grant,
                                         input logic pd_priority);
        if (pd_elig && dbg_elig)
            return pd_priority ? SRC_PD : ~last_grant;
        else if (dbg_elig)
            return SRC_DEBUG;
        else
            return SRC_PD;
    endfunction

endpackage

// File: rtl/auth_request_arbiter_timeout_timer.sv
// Transaction watchdog: counts enabled cycles from a clear and flags the
// last allowed cycle; saturates there so it can never wrap.
`timescale 1ns/1ps
module auth_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + 1'b1;
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/auth_request_arbiter.sv
// Arbitrates the single authentication engine between PD and DEBUG request
// sources and retires each served request with a one-cycle erase pulse.
`timescale 1ns/1ps
module auth_request_arbiter
    import auth_request_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int TO_W           = TO_W_DEFAULT,
    parameter int PD_PRIORITY    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pending_auth_request_PD,
    input  logic [7:0] pending_auth_request_DEBUG,
    input  logic       PD_in_ready,
    input  logic       DEBUG_in_ready,
    input  logic       Ack_in,
    input  logic       auth_msg_ready,
    output logic       auth_start,
    output logic       sel_DEBUG,
    output logic       pending_auth_request_PD_erase,
    output logic       pending_auth_request_DEBUG_erase,
    output logic       busy,
    output logic       timeout_err
);

    arb_state_t state;
    logic       last_grant;
    logic       pd_elig;
    logic       dbg_elig;
    logic       grant_src;
    logic       expired;

    assign pd_elig   = (pending_auth_request_PD != 8'd0) && PD_in_ready;
    assign dbg_elig  = (pending_auth_request_DEBUG != 8'd0) && DEBUG_in_ready;
    assign grant_src = pick_source(pd_elig, dbg_elig, last_grant, PD_PRIORITY != 0);

    auth_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .enable ((state == ST_ISSUE) || (state == ST_WAIT)),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                            <= ST_IDLE;
            last_grant                       <= SRC_DEBUG;
            auth_start                       <= 1'b0;
            sel_DEBUG                        <= 1'b0;
            pending_auth_request_PD_erase    <= 1'b0;
            pending_auth_request_DEBUG_erase <= 1'b0;
            busy                             <= 1'b0;
            timeout_err                      <= 1'b0;
        end else begin
            pending_auth_request_PD_erase    <= 1'b0;
            pending_auth_request_DEBUG_erase <= 1'b0;
            timeout_err                      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pd_elig || dbg_elig) begin
                        sel_DEBUG  <= grant_src;
                        auth_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (Ack_in && !auth_msg_ready) begin
                        auth_start <= 1'b0;
                        state      <= ST_WAIT;
                    end else if (Ack_in || expired) begin
                        // Completion takes precedence over a coincident timeout.
                        auth_start                       <= 1'b0;
                        state                            <= ST_DONE;
                        pending_auth_request_PD_erase    <= (sel_DEBUG == SRC_PD);
                        pending_auth_request_DEBUG_erase <= (sel_DEBUG == SRC_DEBUG);
                        timeout_err                      <= !Ack_in;
                    end
                end
                ST_WAIT: begin
                    if (auth_msg_ready || expired) begin
                        state                            <= ST_DONE;
                        pending_auth_request_PD_erase    <= (sel_DEBUG == SRC_PD);
                        pending_auth_request_DEBUG_erase <= (sel_DEBUG == SRC_DEBUG);
                        timeout_err                      <= !auth_msg_ready;
                    end
                end
                ST_DONE: begin
                    last_grant <= sel_DEBUG;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_auth_request_arbiter.sv
// Scenario bench for auth_request_arbiter: a round-robin and a fixed-priority
// instance share stimulus; expected grants are queued and matched on erase.
`timescale 1ns/1ps
module tb_auth_request_arbiter;
    import auth_request_arbiter_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pd_cnt, dbg_cnt;
    logic       pd_rdy, dbg_rdy, ack, msg_rdy;

    logic rr_start, rr_sel, rr_pde, rr_dbe, rr_busy, rr_to;
    logic fp_start, fp_sel, fp_pde, fp_dbe, fp_busy, fp_to;

    int n_checks = 0;
    int n_fail   = 0;
    bit [1:0] exp_q[$];   // {timeout_err, sel_DEBUG}

    always #5 clk = ~clk;

    auth_request_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(5), .PD_PRIORITY(0)) u_rr (
        .clk(clk), .reset(reset),
        .pending_auth_request_PD(pd_cnt), .pending_auth_request_DEBUG(dbg_cnt),
        .PD_in_ready(pd_rdy), .DEBUG_in_ready(dbg_rdy),
        .Ack_in(ack), .auth_msg_ready(msg_rdy),
        .auth_start(rr_start), .sel_DEBUG(rr_sel),
        .pending_auth_request_PD_erase(rr_pde), .pending_auth_request_DEBUG_erase(rr_dbe),
        .busy(rr_busy), .timeout_err(rr_to)
    );

    auth_request_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(5), .PD_PRIORITY(1)) u_fp (
        .clk(clk), .reset(reset),
        .pending_auth_request_PD(pd_cnt), .pending_auth_request_DEBUG(dbg_cnt),
        .PD_in_ready(pd_rdy), .DEBUG_in_ready(dbg_rdy),
        .Ack_in(ack), .auth_msg_ready(msg_rdy),
        .auth_start(fp_start), .sel_DEBUG(fp_sel),
        .pending_auth_request_PD_erase(fp_pde), .pending_auth_request_DEBUG_erase(fp_dbe),
        .busy(fp_busy), .timeout_err(fp_to)
    );

    task automatic drive_idle();
        pd_cnt = 8'd0; dbg_cnt = 8'd0; pd_rdy = 1'b0; dbg_rdy = 1'b0;
        ack = 1'b0; msg_rdy = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pd_cnt = 8'd5; dbg_cnt = 8'd5; pd_rdy = 1'b1; dbg_rdy = 1'b1; ack = 1'b1; msg_rdy = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rr_start !== 1'b0) begin n_fail++; $display("FAIL reset_auth_start got=%b exp=0", rr_start); end
        n_checks++; if (rr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", rr_busy); end
        n_checks++; if (rr_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got=%b exp=0", rr_sel); end
        n_checks++; if ({rr_pde, rr_dbe, rr_to} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {rr_pde, rr_dbe, rr_to}); end
        n_checks++; if ({fp_start, fp_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_fp got=%b exp=00", {fp_start, fp_busy}); end
        // Counts nonzero but not ready, engine strobes high: nothing may start.
        reset = 1'b1; pd_rdy = 1'b0; dbg_rdy = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({rr_busy, rr_pde, rr_dbe} !== 3'b000) begin n_fail++; $display("FAIL idle_ignore got=%b exp=000", {rr_busy, rr_pde, rr_dbe}); end
        pd_rdy = 1'b1; pd_cnt = 8'd0;
        repeat (2) @(negedge clk);
        n_checks++; if (rr_busy !== 1'b0) begin n_fail++; $display("FAIL zero_count_busy got=%b exp=0", rr_busy); end
        drive_idle();
    endtask

    task automatic test_single_pd();
        int erase_seen;
        bit [1:0] e;
        apply_reset();
        pd_cnt = 8'd3; pd_rdy = 1'b1;
        exp_q.push_back({1'b0, SRC_PD});
        @(negedge clk);
        n_checks++; if ({rr_start, rr_busy, rr_sel} !== 3'b110) begin n_fail++; $display("FAIL pd_grant got=%b exp=110", {rr_start, rr_busy, rr_sel}); end
        @(negedge clk);
        n_checks++; if (rr_start !== 1'b1) begin n_fail++; $display("FAIL pd_start_held got=%b exp=1", rr_start); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; pd_rdy = 1'b0; pd_cnt = 8'd0;
        n_checks++; if ({rr_start, rr_busy} !== 2'b01) begin n_fail++; $display("FAIL pd_wait got=%b exp=01", {rr_start, rr_busy}); end
        erase_seen = 0;
        repeat (4) begin
            @(negedge clk);
            erase_seen += int'(rr_pde) + int'(rr_dbe);
        end
        n_checks++; if (erase_seen != 0) begin n_fail++; $display("FAIL pd_early_erase got=%0d exp=0", erase_seen); end
        msg_rdy = 1'b1;
        @(negedge clk);
        msg_rdy = 1'b0;
        n_checks++; if ({rr_pde, rr_dbe, rr_to} !== 3'b100) begin n_fail++; $display("FAIL pd_erase got=%b exp=100", {rr_pde, rr_dbe, rr_to}); end
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL pd_scoreboard_empty got=0 exp=1"); end
        else begin
            e = exp_q.pop_front();
            n_checks++; if ({rr_to, rr_sel} !== e) begin n_fail++; $display("FAIL pd_scoreboard got=%b exp=%b", {rr_to, rr_sel}, e); end
        end
        @(negedge clk);
        n_checks++; if ({rr_busy, rr_pde} !== 2'b00) begin n_fail++; $display("FAIL pd_after got=%b exp=00", {rr_busy, rr_pde}); end
        drive_idle();
    endtask

    task automatic run_contention(input bit fp);
        logic last, g, pde, dbe, sel;
        bit [1:0] e;
        int cyc;
        apply_reset();
        last = SRC_DEBUG;
        for (int i = 0; i < 4; i++) begin
            g = fp ? SRC_PD : ~last;
            last = g;
            exp_q.push_back({1'b0, g});
        end
        pd_cnt = 8'd4; dbg_cnt = 8'd4; pd_rdy = 1'b1; dbg_rdy = 1'b1; ack = 1'b1; msg_rdy = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            pde = fp ? fp_pde : rr_pde;
            dbe = fp ? fp_dbe : rr_dbe;
            sel = fp ? fp_sel : rr_sel;
            if (pde || dbe) begin
                e = exp_q.pop_front();
                n_checks++; if (pde && dbe) begin n_fail++; $display("FAIL contend%0d_both_erase got=11 exp=one", fp); end
                n_checks++; if ({dbe, sel} !== {e[0], e[0]}) begin n_fail++; $display("FAIL contend%0d_grant got=%b exp=%b", fp, {dbe, sel}, {e[0], e[0]}); end
            end
        end
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL contend%0d_timeout got=%0d_left exp=0_left", fp, exp_q.size());
        end
        drive_idle();
    endtask

    task automatic test_round_robin();
        run_contention(1'b0);
    endtask

    task automatic test_fixed_priority();
        run_contention(1'b1);
    endtask

    task automatic test_timeout();
        int issue;
        bit done;
        bit [1:0] e;
        apply_reset();
        dbg_cnt = 8'd2; dbg_rdy = 1'b1;
        exp_q.push_back({1'b1, SRC_DEBUG});
        issue = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (rr_start) issue++;
            if (rr_pde || rr_dbe) begin
                done = 1'b1;
                n_checks++; if (issue != TO) begin n_fail++; $display("FAIL to_issue_cycles got=%0d exp=%0d", issue, TO); end
                n_checks++; if ({rr_to, rr_dbe, rr_pde, rr_start} !== 4'b1100) begin n_fail++; $display("FAIL to_pulse got=%b exp=1100", {rr_to, rr_dbe, rr_pde, rr_start}); end
                e = exp_q.pop_front();
                n_checks++; if ({rr_to, rr_sel} !== e) begin n_fail++; $display("FAIL to_scoreboard got=%b exp=%b", {rr_to, rr_sel}, e); end
            end
        end
        if (!done) begin n_checks++; n_fail++; $display("FAIL to_no_done got=none exp=erase"); end
        drive_idle();
        @(negedge clk);
        n_checks++; if ({rr_busy, rr_to, rr_dbe} !== 3'b000) begin n_fail++; $display("FAIL to_after got=%b exp=000", {rr_busy, rr_to, rr_dbe}); end
    endtask

    task automatic test_same_cycle();
        bit [1:0] e;
        apply_reset();
        pd_cnt = 8'd1; pd_rdy = 1'b1;
        exp_q.push_back({1'b0, SRC_PD});
        @(negedge clk);
        n_checks++; if (rr_start !== 1'b1) begin n_fail++; $display("FAIL same_start got=%b exp=1", rr_start); end
        ack = 1'b1; msg_rdy = 1'b1;
        @(negedge clk);
        ack = 1'b0; msg_rdy = 1'b0;
        n_checks++; if ({rr_pde, rr_dbe, rr_start, rr_busy, rr_to} !== 5'b10010) begin n_fail++; $display("FAIL same_done got=%b exp=10010", {rr_pde, rr_dbe, rr_start, rr_busy, rr_to}); end
        e = exp_q.pop_front();
        n_checks++; if ({rr_to, rr_sel} !== e) begin n_fail++; $display("FAIL same_scoreboard got=%b exp=%b", {rr_to, rr_sel}, e); end
        drive_idle();
        @(negedge clk);
        n_checks++; if ({rr_busy, rr_pde} !== 2'b00) begin n_fail++; $display("FAIL same_after got=%b exp=00", {rr_busy, rr_pde}); end
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        apply_reset();
        // Complete a PD transaction so the arbiter last served PD.
        pd_cnt = 8'd1; pd_rdy = 1'b1; ack = 1'b1; msg_rdy = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (rr_pde) seen = 1'b1;
        end
        drive_idle();
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rw_first_pd got=none exp=pd_erase"); end
        @(negedge clk);
        dbg_cnt = 8'd1; dbg_rdy = 1'b1;
        @(negedge clk);
        n_checks++; if ({rr_start, rr_sel} !== 2'b11) begin n_fail++; $display("FAIL rw_dbg_grant got=%b exp=11", {rr_start, rr_sel}); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; dbg_rdy = 1'b0;
        n_checks++; if ({rr_start, rr_busy} !== 2'b01) begin n_fail++; $display("FAIL rw_in_wait got=%b exp=01", {rr_start, rr_busy}); end
        reset = 1'b0; msg_rdy = 1'b1;
        @(negedge clk);
        n_checks++; if ({rr_start, rr_sel, rr_pde, rr_dbe, rr_busy, rr_to} !== 6'b0) begin n_fail++; $display("FAIL rw_after_reset got=%b exp=000000", {rr_start, rr_sel, rr_pde, rr_dbe, rr_busy, rr_to}); end
        reset = 1'b1; msg_rdy = 1'b0;
        pd_cnt = 8'd2; dbg_cnt = 8'd2; pd_rdy = 1'b1; dbg_rdy = 1'b1;
        @(negedge clk);
        n_checks++; if ({rr_start, rr_sel} !== {1'b1, SRC_PD}) begin n_fail++; $display("FAIL rw_tie_after_reset got=%b exp=10", {rr_start, rr_sel}); end
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        reset = 1'b0;
        test_reset();
        test_single_pd();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_same_cycle();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
